// File: rtl/keysw_io_ctrl_if.sv
// Data-bus slice seen by the key/switch input device: MEM-stage address and
// strobes in, combinational read data and select out.
interface keysw_io_ctrl_if;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic        WE;
  logic        RE;
  logic [15:0] RDATA;
  logic        SEL;

  modport master (output ADDR, output WDATA, output WE, output RE,
                  input  RDATA, input SEL);
  modport slave  (input  ADDR, input  WDATA, input  WE, input  RE,
                  output RDATA, output SEL);
endinterface

// File: rtl/keysw_io_ctrl.sv
// Memory-mapped KEY/SW input device: two-flop synchronizers, vector debounce,
// data and control/status registers, and a registered level interrupt.
module keysw_io_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_BITS   = 20,
  parameter logic [15:0] ADDR_KDATA = 16'hFFF0,
  parameter logic [15:0] ADDR_SDATA = 16'hFFF2,
  parameter logic [15:0] ADDR_KCTRL = 16'hFFF4,
  parameter logic [15:0] ADDR_SCTRL = 16'hFFF6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            KEY,
  input  logic [9:0]            SW,
  keysw_io_ctrl_if.slave        bus,
  output logic                  IRQ
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEB_CYCLES - 1);

  logic [3:0]          key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [3:0]          key_cand_q, key_cand_d, key_deb_q, key_deb_d;
  logic [CNT_BITS-1:0] key_cnt_q, key_cnt_d;
  logic [9:0]          sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [9:0]          sw_cand_q, sw_cand_d, sw_deb_q, sw_deb_d;
  logic [CNT_BITS-1:0] sw_cnt_q, sw_cnt_d;
  logic krdy_q, krdy_d, kovr_q, kovr_d, kie_q, kie_d;
  logic srdy_q, srdy_d, sovr_q, sovr_d, sie_q, sie_d;
  logic irq_q, irq_d;
  logic key_acc, sw_acc;
  logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
  logic unused_wdata;

  assign unused_wdata = ^{bus.WDATA[15:9], bus.WDATA[7:2], bus.WDATA[0]};

  // Debounce: a new candidate restarts the count; once saturated, accept it.
  always_comb begin
    key_s1_d   = KEY;
    key_s2_d   = key_s1_q;
    key_cand_d = key_cand_q;
    key_cnt_d  = key_cnt_q;
    key_deb_d  = key_deb_q;
    key_acc    = 1'b0;
    if (key_s2_q != key_cand_q) begin
      key_cand_d = key_s2_q;
      key_cnt_d  = '0;
    end else if (key_cnt_q < CntMax) begin
      key_cnt_d = key_cnt_q + 1'b1;
    end else if (key_deb_q != key_cand_q) begin
      key_deb_d = key_cand_q;
      key_acc   = 1'b1;
    end

    sw_s1_d   = SW;
    sw_s2_d   = sw_s1_q;
    sw_cand_d = sw_cand_q;
    sw_cnt_d  = sw_cnt_q;
    sw_deb_d  = sw_deb_q;
    sw_acc    = 1'b0;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q < CntMax) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end else if (sw_deb_q != sw_cand_q) begin
      sw_deb_d = sw_cand_q;
      sw_acc   = 1'b1;
    end
  end

  always_comb begin
    hit_kdata = (bus.ADDR == ADDR_KDATA);
    hit_sdata = (bus.ADDR == ADDR_SDATA);
    hit_kctrl = (bus.ADDR == ADDR_KCTRL);
    hit_sctrl = (bus.ADDR == ADDR_SCTRL);
    bus.SEL   = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;
    bus.RDATA = 16'h0000;
    if (hit_kdata)      bus.RDATA = {12'b0, key_deb_q};
    else if (hit_sdata) bus.RDATA = {6'b0, sw_deb_q};
    else if (hit_kctrl) bus.RDATA = {7'b0, kie_q, 6'b0, kovr_q, krdy_q};
    else if (hit_sctrl) bus.RDATA = {7'b0, sie_q, 6'b0, sovr_q, srdy_q};
  end

  // Status: accept events are applied last so they win over clears.
  always_comb begin
    krdy_d = krdy_q;
    kovr_d = kovr_q;
    kie_d  = kie_q;
    srdy_d = srdy_q;
    sovr_d = sovr_q;
    sie_d  = sie_q;
    if (bus.WE && hit_kctrl) begin
      kie_d = bus.WDATA[8];
      if (!bus.WDATA[1]) kovr_d = 1'b0;
    end
    if (bus.WE && hit_sctrl) begin
      sie_d = bus.WDATA[8];
      if (!bus.WDATA[1]) sovr_d = 1'b0;
    end
    if (bus.RE && hit_kdata) krdy_d = 1'b0;
    if (bus.RE && hit_sdata) srdy_d = 1'b0;
    if (key_acc) begin
      if (krdy_q) kovr_d = 1'b1;
      krdy_d = 1'b1;
    end
    if (sw_acc) begin
      if (srdy_q) sovr_d = 1'b1;
      srdy_d = 1'b1;
    end
    irq_d = (kie_q & krdy_q) | (sie_q & srdy_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_s1_q   <= 4'hF;
      key_s2_q   <= 4'hF;
      key_cand_q <= 4'hF;
      key_deb_q  <= 4'hF;
      key_cnt_q  <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_cand_q  <= '0;
      sw_deb_q   <= '0;
      sw_cnt_q   <= '0;
      krdy_q     <= 1'b0;
      kovr_q     <= 1'b0;
      kie_q      <= 1'b0;
      srdy_q     <= 1'b0;
      sovr_q     <= 1'b0;
      sie_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_cand_q <= key_cand_d;
      key_deb_q  <= key_deb_d;
      key_cnt_q  <= key_cnt_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      sw_cand_q  <= sw_cand_d;
      sw_deb_q   <= sw_deb_d;
      sw_cnt_q   <= sw_cnt_d;
      krdy_q     <= krdy_d;
      kovr_q     <= kovr_d;
      kie_q      <= kie_d;
      srdy_q     <= srdy_d;
      sovr_q     <= sovr_d;
      sie_q      <= sie_d;
      irq_q      <= irq_d;
    end
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_keysw_io_ctrl.sv
// Bench for keysw_io_ctrl: reset-state address table, directed multi-cycle
// sequences, then random traffic against a sample-history reference model.
module tb_keysw_io_ctrl;

  localparam int unsigned DEB = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic       IRQ;
  int         n_checks = 0;
  int         n_fail = 0;

  keysw_io_ctrl_if bus ();

  keysw_io_ctrl #(
    .DEB_CYCLES (DEB),
    .CNT_BITS   (20)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .KEY   (KEY),
    .SW    (SW),
    .bus   (bus),
    .IRQ   (IRQ)
  );

  always #5 CLK = ~CLK;

  // Reference model: an input vector is accepted once the last DEB+1 values
  // seen by the debouncer (pin samples delayed by the two sync stages) agree.
  logic [9:0] m_kq[$];
  logic [9:0] m_sq[$];
  logic [3:0] m_kdeb = 4'hF;
  logic [9:0] m_sdeb = '0;
  logic m_krdy = 0, m_kovr = 0, m_kie = 0, m_srdy = 0, m_sovr = 0, m_sie = 0;
  logic m_irq = 0;
  logic k_acc, s_acc, k_old, s_old;

  function automatic logic settled(input logic [9:0] q[$]);
    if (q.size() < DEB + 3) return 1'b0;
    for (int i = 1; i <= DEB; i++) if (q[i] != q[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_kq.delete();
      m_sq.delete();
      m_kdeb = 4'hF; m_sdeb = '0;
      m_krdy = 0; m_kovr = 0; m_kie = 0;
      m_srdy = 0; m_sovr = 0; m_sie = 0;
      m_irq = 0;
    end else begin
      m_kq.push_back({6'b0, KEY});
      if (m_kq.size() > DEB + 3) void'(m_kq.pop_front());
      m_sq.push_back(SW);
      if (m_sq.size() > DEB + 3) void'(m_sq.pop_front());
      k_acc = settled(m_kq) && (m_kq[0][3:0] != m_kdeb);
      s_acc = settled(m_sq) && (m_sq[0] != m_sdeb);
      k_old = m_krdy;
      s_old = m_srdy;
      m_irq = (m_kie & m_krdy) | (m_sie & m_srdy);
      if (bus.WE && bus.ADDR == 16'hFFF4) begin
        m_kie = bus.WDATA[8];
        if (!bus.WDATA[1]) m_kovr = 0;
      end
      if (bus.WE && bus.ADDR == 16'hFFF6) begin
        m_sie = bus.WDATA[8];
        if (!bus.WDATA[1]) m_sovr = 0;
      end
      if (bus.RE && bus.ADDR == 16'hFFF0) m_krdy = 0;
      if (bus.RE && bus.ADDR == 16'hFFF2) m_srdy = 0;
      if (k_acc) begin
        m_kdeb = m_kq[0][3:0];
        if (k_old) m_kovr = 1;
        m_krdy = 1;
      end
      if (s_acc) begin
        m_sdeb = m_sq[0];
        if (s_old) m_sovr = 1;
        m_srdy = 1;
      end
    end
  end

  function automatic logic [16:0] model_rd(input logic [15:0] a);
    case (a)
      16'hFFF0: return {1'b1, 12'b0, m_kdeb};
      16'hFFF2: return {1'b1, 6'b0, m_sdeb};
      16'hFFF4: return {1'b1, 7'b0, m_kie, 6'b0, m_kovr, m_krdy};
      16'hFFF6: return {1'b1, 7'b0, m_sie, 6'b0, m_sovr, m_srdy};
      default:  return 17'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reg(input string name, input logic [15:0] a, input logic [15:0] exp);
    bus.ADDR = a;
    #1;
    chk(name, bus.RDATA, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.ADDR  = a;
    bus.WDATA = d;
    bus.WE    = 1'b1;
    @(negedge CLK);
    bus.WE    = 1'b0;
  endtask

  task automatic rd_clr(input string name, input logic [15:0] a, input logic [15:0] exp);
    bus.ADDR = a;
    bus.RE   = 1'b1;
    #1;
    chk(name, bus.RDATA, exp);
    @(negedge CLK);
    bus.RE   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        sel;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] exp_rd;
    int r;

    vecs[0] = '{16'hFFF0, 16'h000F, 1'b1};
    vecs[1] = '{16'hFFF2, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFF4, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFF6, 16'h0000, 1'b1};
    vecs[4] = '{16'hFFF8, 16'h0000, 1'b0};
    vecs[5] = '{16'hFFF1, 16'h0000, 1'b0};
    vecs[6] = '{16'hFFEF, 16'h0000, 1'b0};
    vecs[7] = '{16'h7FF0, 16'h0000, 1'b0};

    bus.ADDR = 16'h0000; bus.WDATA = 16'h0000; bus.WE = 1'b0; bus.RE = 1'b0;
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      bus.ADDR = vecs[i].addr;
      #1;
      chk($sformatf("reset_rdata[%0d]", i), bus.RDATA, vecs[i].rdata);
      chk($sformatf("reset_sel[%0d]", i), {15'b0, bus.SEL}, {15'b0, vecs[i].sel});
    end
    chk("reset_irq", {15'b0, IRQ}, 16'h0);
    @(negedge CLK);
    RESET = 1'b0;
    cyc(10);

    // Key press: debounced value appears on the 7th edge.
    KEY = 4'hE;
    cyc(6);
    chk_reg("t1_kdata_early", 16'hFFF0, 16'h000F);
    cyc(1);
    chk_reg("t1_kdata", 16'hFFF0, 16'h000E);
    chk_reg("t1_kctrl", 16'hFFF4, 16'h0001);
    chk("t1_irq", {15'b0, IRQ}, 16'h0);

    // Switch glitch of DEB cycles is rejected, then a held value is accepted.
    SW = 10'h3FF;
    cyc(4);
    SW = 10'h000;
    cyc(10);
    chk_reg("t2_glitch_sdata", 16'hFFF2, 16'h0000);
    chk_reg("t2_glitch_sctrl", 16'hFFF6, 16'h0000);
    SW = 10'h155;
    cyc(6);
    chk_reg("t2_sdata_early", 16'hFFF2, 16'h0000);
    cyc(1);
    chk_reg("t2_sdata", 16'hFFF2, 16'h0155);
    chk_reg("t2_sctrl", 16'hFFF6, 16'h0001);

    // Second key accept without a read sets overrun; writing 0 clears it.
    KEY = 4'hF;
    cyc(7);
    chk_reg("t4_kdata", 16'hFFF0, 16'h000F);
    chk_reg("t4_kctrl_ovr", 16'hFFF4, 16'h0003);
    wr(16'hFFF4, 16'h0000);
    chk_reg("t4_kctrl_clr", 16'hFFF4, 16'h0001);

    // Interrupt path: enable, accept, read clears RDY, IRQ follows a cycle later.
    rd_clr("t3_pre_read", 16'hFFF0, 16'h000F);
    wr(16'hFFF4, 16'h0100);
    chk_reg("t3_kctrl_ie", 16'hFFF4, 16'h0100);
    chk("t3_irq_idle", {15'b0, IRQ}, 16'h0);
    KEY = 4'hE;
    cyc(7);
    chk_reg("t3_kctrl_rdy", 16'hFFF4, 16'h0101);
    chk("t3_irq_lag", {15'b0, IRQ}, 16'h0);
    cyc(1);
    chk("t3_irq_set", {15'b0, IRQ}, 16'h1);
    rd_clr("t3_kdata_read", 16'hFFF0, 16'h000E);
    chk("t3_irq_hold", {15'b0, IRQ}, 16'h1);
    chk_reg("t3_kctrl_after", 16'hFFF4, 16'h0100);
    cyc(1);
    chk("t3_irq_drop", {15'b0, IRQ}, 16'h0);

    // Read of KDATA in the accept cycle: the set wins.
    KEY = 4'hF;
    cyc(6);
    bus.ADDR = 16'hFFF0;
    bus.RE   = 1'b1;
    @(negedge CLK);
    bus.RE   = 1'b0;
    chk_reg("t5_kctrl_setwins", 16'hFFF4, 16'h0101);
    chk_reg("t5_unmapped_rdata", 16'hFFF8, 16'h0000);
    chk("t5_unmapped_sel", {15'b0, bus.SEL}, 16'h0);

    // Asynchronous reset with pending RDY and interrupt enabled.
    wr(16'hFFF6, 16'h0100);
    cyc(1);
    chk("t6_irq_pre", {15'b0, IRQ}, 16'h1);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_irq_async", {15'b0, IRQ}, 16'h0);
    chk_reg("t6_kdata", 16'hFFF0, 16'h000F);
    chk_reg("t6_sdata", 16'hFFF2, 16'h0000);
    chk_reg("t6_kctrl", 16'hFFF4, 16'h0000);
    chk_reg("t6_sctrl", 16'hFFF6, 16'h0000);
    cyc(3);
    RESET = 1'b0;
    cyc(6);
    chk_reg("t6_sw_early", 16'hFFF2, 16'h0000);
    cyc(1);
    chk_reg("t6_sw_accept", 16'hFFF2, 16'h0155);
    chk_reg("t6_sctrl_accept", 16'hFFF6, 16'h0001);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) KEY = 4'($urandom);
      if ($urandom_range(7) == 0) SW = 10'($urandom);
      r = int'($urandom_range(5));
      if (r < 4) bus.ADDR = 16'hFFF0 + 16'(2 * r);
      else if (r == 4) bus.ADDR = 16'($urandom);
      else bus.ADDR = 16'hFFF1;
      bus.RE    = ($urandom_range(3) == 0);
      bus.WE    = ($urandom_range(5) == 0);
      bus.WDATA = 16'($urandom);
      #1;
      exp_rd = model_rd(bus.ADDR);
      chk("rand_rdata", bus.RDATA, exp_rd[15:0]);
      chk("rand_sel", {15'b0, bus.SEL}, {15'b0, exp_rd[16]});
      chk("rand_irq", {15'b0, IRQ}, {15'b0, m_irq});
    end
    bus.RE = 1'b0;
    bus.WE = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
